display_mux: RTL and testbench
==============================

DISPLAY_MUX -- requirements
Module: display_mux

Interface
- REQ-001 SHALL have parameter SCAN_P, default 4, meaning clk cycles per digit slot (legal range 2..255).
- REQ-002 SHALL have port clk, input, 1 bit: system clock (1 kHz tick domain).
- REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
- REQ-004 SHALL have port valor, input, 14 bits: unsigned binary value to display.
- REQ-005 SHALL have port carregar, input, 1 bit: single-cycle load strobe for valor and pontos.
- REQ-006 SHALL have port pontos, input, 4 bits: decimal point per digit, bit i = digit i.
- REQ-007 SHALL have port apagar_zeros, input, 1 bit: leading-zero blanking enable, sampled live.
- REQ-008 SHALL have port ocupado, output, 1 bit: conversion in progress.
- REQ-009 SHALL have port hex_en, output, 4 bits, active-high: digit enable, bit 0 = rightmost digit.
- REQ-010 SHALL have port hex_led, output, 8 bits, active-high: bit7..bit0 = A, B, C, D, E, F, G, POINT.

Function
- REQ-011 SHALL, on carregar=1 with ocupado=0, latch valor (saturated to 9999 if greater) and pontos, and set ocupado=1 on the next edge.
- REQ-012 SHALL ignore carregar while ocupado=1 (no queuing, no restart).
- REQ-013 SHALL convert binary to 4 BCD digits by sequential shift-add-3, one shift per cycle, 14 shift cycles.
- REQ-014 SHALL update all 4 displayed digit registers and the point register atomically on the edge ending the 14th shift; ocupado SHALL fall on that same edge (ocupado high exactly 14 cycles).
- REQ-015 SHALL keep the previous digits displayed, unchanged, throughout conversion.
- REQ-016 SHALL scan digits in order 0,1,2,3,0,... each slot lasting SCAN_P cycles, via a slot counter 0..SCAN_P-1 and a 2-bit digit index that wraps 3->0.
- REQ-017 SHALL drive hex_en=0000 and hex_led=00000000 during cycle 0 of every slot (anti-ghosting blank).
- REQ-018 SHALL drive hex_en one-hot on the current digit index, and hex_led with that digit's pattern, during cycles 1..SCAN_P-1 of the slot.
- REQ-019 SHALL register hex_en and hex_led (no combinational path from inputs to outputs).
- REQ-020 SHALL encode segments A..G as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- REQ-021 SHALL, with apagar_zeros=1, blank segments A..G of digit 3, 2, 1 when that digit and all higher digits are 0; digit 0 is never blanked.
- REQ-022 SHALL drive POINT from the latched pontos bit of the current digit, including on blanked digits.
- REQ-023 SHALL keep scanning unaffected by carregar, conversion, or apagar_zeros changes.

Reset
- REQ-024 SHALL, while rst=0, force hex_en=0000, hex_led=00000000, ocupado=0, digit registers=0, point register=0000, slot counter=0, digit index=0, conversion state cleared.
- REQ-025 SHALL abort any in-flight conversion on reset without updating digit registers; after release, the first slot starts at digit 0, cycle 0.

Verification
- REQ-026 Reset then release, SCAN_P=4, apagar_zeros=0 -> slot cycle 0 blank; cycles 1-3 hex_en=0001, hex_led=11111100; 16-cycle frame repeats.
- REQ-027 carregar with valor=1234, pontos=0100 -> ocupado high 14 cycles; then digit 0 = 01100110 ("4"), digit 1 = 11110010 ("3"), digit 2 = 11011011 ("2" + point), digit 3 = 01100000 ("1").
- REQ-028 valor=10000, carregar -> all digits show "9" (11110110).
- REQ-029 valor=7, apagar_zeros=1 -> digits 3..1 hex_led=00000000 while hex_en still asserted; digit 0 = 11100000; toggle apagar_zeros=0 -> digits 3..1 = 11111100.
- REQ-030 Second carregar (valor=5555) 5 cycles after a first (valor=42) -> ignored; display shows 0042 after the first conversion.
- REQ-031 rst asserted at shift cycle 7 of a conversion -> outputs zero immediately (asynchronous), ocupado=0; display after release shows 0000.

Source files
------------

// File: rtl/display_mux.sv
// 4-digit multiplexed 7-segment driver with a sequential binary-to-BCD converter.
module display_mux #(
  parameter int unsigned SCAN_P = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] valor,
  input  logic        carregar,
  input  logic [3:0]  pontos,
  input  logic        apagar_zeros,
  output logic        ocupado,
  output logic [3:0]  hex_en,
  output logic [7:0]  hex_led
);

  localparam int unsigned VAL_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SH_W   = 4;
  localparam int unsigned CNT_W  = 8;
  localparam logic [VAL_W-1:0] MAX_VAL    = VAL_W'(9999);
  localparam logic [SH_W-1:0]  LAST_SHIFT = SH_W'(VAL_W - 1);
  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(SCAN_P - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             state, state_nx;
  logic [VAL_W-1:0]   bin, bin_nx;
  logic [BCD_W-1:0]   bcd, bcd_nx;
  logic [SH_W-1:0]    shcnt, shcnt_nx;
  logic [3:0]         pts_lat, pts_lat_nx;
  logic [BCD_W-1:0]   digits, digits_nx;
  logic [3:0]         pts_disp, pts_disp_nx;
  logic               ocupado_nx;

  logic [CNT_W-1:0]   slot, slot_nx;
  logic [1:0]         idx, idx_nx;
  logic [3:0]         hex_en_nx;
  logic [7:0]         hex_led_nx;

  // Seven-segment pattern A..G for a BCD digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bin      <= '0;
      bcd      <= '0;
      shcnt    <= '0;
      pts_lat  <= '0;
      digits   <= '0;
      pts_disp <= '0;
      ocupado  <= 1'b0;
      slot     <= '0;
      idx      <= '0;
      hex_en   <= '0;
      hex_led  <= '0;
    end else begin
      state    <= state_nx;
      bin      <= bin_nx;
      bcd      <= bcd_nx;
      shcnt    <= shcnt_nx;
      pts_lat  <= pts_lat_nx;
      digits   <= digits_nx;
      pts_disp <= pts_disp_nx;
      ocupado  <= ocupado_nx;
      slot     <= slot_nx;
      idx      <= idx_nx;
      hex_en   <= hex_en_nx;
      hex_led  <= hex_led_nx;
    end
  end

  // Conversion FSM: load, then 14 add-3/shift steps; display updates on the last one
  always_comb begin
    logic [BCD_W-1:0] adj;
    state_nx    = state;
    bin_nx      = bin;
    bcd_nx      = bcd;
    shcnt_nx    = shcnt;
    pts_lat_nx  = pts_lat;
    digits_nx   = digits;
    pts_disp_nx = pts_disp;
    ocupado_nx  = 1'b0;
    adj         = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    case (state)
      S_IDLE: begin
        if (carregar) begin
          bin_nx     = (valor > MAX_VAL) ? MAX_VAL : valor;
          bcd_nx     = '0;
          shcnt_nx   = '0;
          pts_lat_nx = pontos;
          ocupado_nx = 1'b1;
          state_nx   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_nx     = {adj[BCD_W-2:0], bin[VAL_W-1]};
        bin_nx     = {bin[VAL_W-2:0], 1'b0};
        shcnt_nx   = shcnt + SH_W'(1);
        ocupado_nx = 1'b1;
        if (shcnt == LAST_SHIFT) begin
          digits_nx   = {adj[BCD_W-2:0], bin[VAL_W-1]};
          pts_disp_nx = pts_lat;
          ocupado_nx  = 1'b0;
          state_nx    = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Scan counters and next output pattern; outputs reflect the post-edge slot position
  always_comb begin
    logic [3:0] cur;
    logic [3:0] blank;
    slot_nx = (slot == LAST_SLOT) ? '0 : slot + CNT_W'(1);
    idx_nx  = (slot == LAST_SLOT) ? idx + 2'd1 : idx;
    cur     = digits[{idx_nx, 2'b00} +: 4];
    blank[3] = apagar_zeros && (digits[15:12] == 4'd0);
    blank[2] = blank[3] && (digits[11:8] == 4'd0);
    blank[1] = blank[2] && (digits[7:4] == 4'd0);
    blank[0] = 1'b0;
    hex_en_nx  = '0;
    hex_led_nx = '0;
    if (slot_nx != '0) begin
      hex_en_nx  = 4'b0001 << idx_nx;
      hex_led_nx = {(blank[idx_nx] ? 7'b0000000 : seg7(cur)), pts_disp[idx_nx]};
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Directed self-checking bench for display_mux.
module tb_display_mux;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] valor = '0;
  logic        carregar = 1'b0;
  logic [3:0]  pontos = '0;
  logic        apagar_zeros = 1'b0;
  logic        ocupado;
  logic [3:0]  hex_en;
  logic [7:0]  hex_led;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  display_mux #(.SCAN_P(P)) dut (
    .clk(clk), .rst(rst), .valor(valor), .carregar(carregar), .pontos(pontos),
    .apagar_zeros(apagar_zeros), .ocupado(ocupado), .hex_en(hex_en), .hex_led(hex_led)
  );

  always #5 clk = ~clk;

  // Reference frame position: rising edges since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    logic [13:0] valor;
    logic [3:0]  pontos;
    logic        apagar;
    logic [31:0] exp;   // {d3,d2,d1,d0} hex_led patterns
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
    else passed++;
  endtask

  // Check every cycle of one full 4-digit frame against expected patterns
  task automatic check_frame(input string name, input logic [31:0] exp);
    int slot, dig;
    logic [3:0] een;
    logic [7:0] eled;
    for (int k = 0; k < 4 * P; k++) begin
      @(negedge clk);
      slot = cyc % P;
      dig  = (cyc / P) % 4;
      een  = (slot == 0) ? 4'b0000 : (4'b0001 << dig);
      eled = (slot == 0) ? 8'h00 : exp[dig*8 +: 8];
      chk($sformatf("%s_en_d%0d_s%0d", name, dig, slot), 32'(hex_en), 32'(een));
      chk($sformatf("%s_led_d%0d_s%0d", name, dig, slot), 32'(hex_led), 32'(eled));
    end
  endtask

  // Pulse carregar, measure ocupado width; optionally strobe a second load at busy cycle 'intr'
  task automatic load(input string name, input logic [13:0] v, input logic [3:0] p, input int intr);
    int n;
    @(negedge clk);
    valor = v; pontos = p; carregar = 1'b1;
    @(negedge clk);
    carregar = 1'b0;
    chk({name, "_busy_start"}, 32'(ocupado), 32'd1);
    n = 0;
    while (ocupado && n < 40) begin
      n++;
      if (n == intr) begin valor = 14'd5555; pontos = 4'b1111; carregar = 1'b1; end
      @(negedge clk);
      carregar = 1'b0;
    end
    chk({name, "_busy_len"}, 32'(n), 32'd14);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{14'd1234,  4'b0100, 1'b0, {8'h60, 8'hDB, 8'hF2, 8'h66}};
    vecs[1] = '{14'd10000, 4'b0000, 1'b0, {8'hF6, 8'hF6, 8'hF6, 8'hF6}};
    vecs[2] = '{14'd16383, 4'b1111, 1'b0, {8'hF7, 8'hF7, 8'hF7, 8'hF7}};
    vecs[3] = '{14'd9999,  4'b0000, 1'b0, {8'hF6, 8'hF6, 8'hF6, 8'hF6}};
    vecs[4] = '{14'd0,     4'b1010, 1'b1, {8'h01, 8'h00, 8'h01, 8'hFC}};
    vecs[5] = '{14'd1005,  4'b0000, 1'b1, {8'h60, 8'hFC, 8'hFC, 8'hB6}};
    vecs[6] = '{14'd42,    4'b0000, 1'b1, {8'h00, 8'h00, 8'h66, 8'hDA}};
    vecs[7] = '{14'd7,     4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'hE0}};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(hex_en), 32'd0);
    chk("rst_led", 32'(hex_led), 32'd0);
    chk("rst_busy", 32'(ocupado), 32'd0);
    rst = 1'b1;
    chk("rel_led", 32'(hex_led), 32'd0);
    check_frame("rst_frame", {4{8'hFC}});
    check_frame("rst_frame2", {4{8'hFC}});

    // Table-driven conversions
    for (int i = 0; i < 8; i++) begin
      apagar_zeros = vecs[i].apagar;
      load($sformatf("v%0d", i), vecs[i].valor, vecs[i].pontos, 0);
      check_frame($sformatf("v%0d", i), vecs[i].exp);
    end

    // Live blanking toggle on the value 7
    apagar_zeros = 1'b0;
    @(negedge clk);
    check_frame("unblank", {8'hFC, 8'hFC, 8'hFC, 8'hE0});

    // Second load while busy is ignored
    load("ign", 14'd42, 4'b0000, 5);
    check_frame("ign", {8'hFC, 8'hFC, 8'h66, 8'hDA});
    chk("ign_idle", 32'(ocupado), 32'd0);

    // Reset mid-conversion aborts without updating the display
    @(negedge clk);
    valor = 14'd1234; pontos = 4'b1111; carregar = 1'b1;
    @(negedge clk);
    carregar = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_busy_before", 32'(ocupado), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_en", 32'(hex_en), 32'd0);
    chk("abort_led", 32'(hex_led), 32'd0);
    chk("abort_busy", 32'(ocupado), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check_frame("abort_frame", {4{8'hFC}});
    chk("abort_idle", 32'(ocupado), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
